decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
RV64I instruction decode stage sitting directly upstream of the 32x64 register file.
- Splits each fetched instruction into source and destination register fields and drives the register-file read addresses.
- Bypasses same-cycle writeback data and generates the sign-extended immediate.
- Detects load-use hazards and registers the result into the ID/EX pipeline register with a valid/ready handshake towards execute.

Parameters:
XLEN, 64, datapath width of PC, operands and immediate
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch beat present
if_ready  out  1  decode accepts the fetch beat this cycle
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
rs1  out  5  register-file read address 1 (combinational, = if_instr[19:15])
rs2  out  5  register-file read address 2 (combinational, = if_instr[24:20])
rf_rdata1  in  XLEN  register-file read data 1
rf_rdata2  in  XLEN  register-file read data 2
wb_regwrite  in  1  writeback write enable (same signal sent to the register file)
wb_rd  in  5  writeback destination register
wb_data  in  XLEN  writeback data
flush  in  1  kill the decode and ID/EX contents (branch/jump redirect)
ex_ready  in  1  execute accepts the ID/EX beat
ex_valid  out  1  ID/EX beat valid
ex_pc  out  XLEN  registered PC
ex_op1  out  XLEN  registered rs1 value
ex_op2  out  XLEN  registered rs2 value
ex_imm  out  XLEN  registered immediate
ex_rd  out  5  destination register (0 if none)
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7  out  7  instr[31:25]
ex_regwrite  out  1  instruction writes rd
ex_memread  out  1  load
ex_memwrite  out  1  store
ex_alusrc  out  1  second ALU operand is the immediate
ex_illegal  out  1  unrecognised opcode
bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset: all registered outputs are 0, including ex_valid and bubble_cnt. Reset acts asynchronously on assertion; release is synchronous to clk.
- Opcode decode:
  - LUI 0110111, AUIPC 0010111, JAL 1101111 and JALR 1100111 write rd.
  - BRANCH 1100011 does not write rd.
  - LOAD 0000011 writes rd and sets memread.
  - STORE 0100011 sets memwrite and does not write rd.
  - OP-IMM 0010011, OP-IMM-32 0011011, OP 0110011 and OP-32 0111011 write rd.
  - Any other opcode sets ex_illegal=1 and clears regwrite/memread/memwrite.
  - ex_rd is forced to 0 when regwrite=0.
- alusrc: 1 for LOAD, STORE, OP-IMM, OP-IMM-32, JALR, LUI, AUIPC; 0 otherwise.
- Immediate, sign-extended from instr[31] to XLEN:
  - I (LOAD, OP-IMM*, JALR): instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: 0.
- Source usage:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by OP, OP-32, STORE and BRANCH.
- WB bypass: if wb_regwrite && wb_rd!=0 && wb_rd==rs1, op1 = wb_data, else rf_rdata1. Same rule for rs2/op2. x0 always reads 0 regardless of rf data.
- Load-use hazard is set when ex_valid && ex_memread && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)).
- Pipeline register load enable: load = !ex_valid || ex_ready.
- if_ready = flush || (load && !hazard).
- On a clock edge, in priority order:
  1. flush: ex_valid←0 and the incoming beat is consumed and dropped.
  2. load && hazard && if_valid: ex_valid←0 (bubble) and bubble_cnt increments unless all ones.
  3. load && if_valid: capture all ex_* fields and set ex_valid←1.
  4. load && !if_valid: ex_valid←0.
  5. Otherwise: hold every ex_* output unchanged.
- A hazard produces exactly one bubble. The following cycle ex_valid=0, so the instruction proceeds, relying on MEM→EX forwarding downstream.
- While if_ready=0, upstream holds if_instr stable. Operands are re-read and re-bypassed every cycle, and only the values present at the capture edge are registered.
- ex_* data fields hold their last values when ex_valid=0; consumers must qualify them with ex_valid.
- Reset mid-operation clears ex_valid immediately; in-flight ID/EX content is lost.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OPC_LUI … OPC_OP32);
  - an immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE);
  - a ctrl_t struct {regwrite, memread, memwrite, alusrc, illegal}.
- One sub-module, imm_gen: a combinational instruction → XLEN immediate generator, reused later by the branch unit.

Test Plan:
- addi x5,x0,-1 (0xFFF00293), if_valid=1, ex_ready=1 → next cycle ex_valid=1, ex_imm=0xFFFFFFFFFFFFFFFF, ex_rd=5, ex_regwrite=1, ex_alusrc=1.
- add x3,x1,x2 with rf_rdata1=0x10, and wb_regwrite=1, wb_rd=2, wb_data=0x99 in the same cycle → ex_op1=0x10, ex_op2=0x99. Repeat with wb_rd=0 → ex_op2=rf_rdata2.
- ld x7,0(x1) accepted, then add x8,x7,x7 presented → one cycle if_ready=0, ex_valid=0, bubble_cnt=1. The next cycle add is captured with ex_rd=8.
- ex_ready=0 for 3 cycles with sw x2,8(x1) in ID/EX and another instruction waiting → ex_* outputs stable, if_ready=0. Release → new beat captured on the first cycle ex_ready=1.
- flush=1 while if_valid=1 and ex_valid=1 → if_ready=1, next cycle ex_valid=0. Opcode 0x7F → ex_illegal=1, ex_regwrite=0, ex_rd=0. Force 0xFFFF+2 hazards → bubble_cnt stays 0xFFFF. Assert rst_n=0 mid-stream → ex_valid=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV64I decode definitions: opcode constants, immediate formats and
// the per-opcode control bundle used by decode and, later, the branch unit.
package rv_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic alusrc;
        logic illegal;
    } ctrl_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        imm_fmt_e fmt;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                                  fmt = IMM_S;
            OPC_BRANCH:                                 fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
            OPC_JAL:                                    fmt = IMM_J;
            default:                                    fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // Unknown opcodes must never write state, so every enable stays low for them.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JALR: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OPC_JAL: c.regwrite = 1'b1;
            OPC_BRANCH: c.regwrite = 1'b0;
            OPC_LOAD: begin
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.alusrc   = 1'b1;
            end
            OPC_STORE: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OPC_OP, OPC_OP32: c.regwrite = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP || opc == OPC_OP32 || opc == OPC_STORE || opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV64I immediate generator: instruction word in, sign-extended
// XLEN immediate out. Formats without an immediate produce zero.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    imm_fmt_e w_fmt;
    logic     w_sign;

    assign w_fmt  = imm_fmt(i_instr[6:0]);
    assign w_sign = i_instr[31];

    always_comb begin
        o_imm = '0;
        case (w_fmt)
            IMM_I: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:20]};
            IMM_S: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {{(XLEN-32){w_sign}}, i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: register-file addressing, writeback bypass, immediate
// generation, load-use bubble insertion and the ID/EX pipeline register.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Handshake: a beat moves on a rising edge when valid && ready are both
    // high on that edge. Upstream holds if_instr/if_pc stable while
    // if_valid && !if_ready; ex_valid stays high with all ex_* fields frozen
    // until execute raises ex_ready. flush makes if_ready high so the pending
    // fetch beat is consumed and discarded in the same edge.

    logic [6:0]       w_opcode;
    ctrl_t            w_ctrl;
    logic             w_use1;
    logic             w_use2;
    logic [4:0]       w_rd;
    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;
    logic [XLEN-1:0]  w_imm;
    logic             w_hazard;
    logic             w_load;
    logic             w_cnt_full;

    logic             r_ex_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rd;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_opcode = if_instr[6:0];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];
    assign w_ctrl   = decode_ctrl(w_opcode);
    assign w_use1   = uses_rs1(w_opcode);
    assign w_use2   = uses_rs2(w_opcode);
    assign w_rd     = w_ctrl.regwrite ? if_instr[11:7] : 5'd0;

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .i_instr(if_instr),
        .o_imm  (w_imm)
    );

    // The register file writes at the same edge we capture, so a matching
    // writeback must be forwarded here; x0 is hardwired to zero.
    always_comb begin
        w_op1 = rf_rdata1;
        if (rs1 == 5'd0) begin
            w_op1 = '0;
        end else if (wb_regwrite && (wb_rd == rs1)) begin
            w_op1 = wb_data;
        end
    end

    always_comb begin
        w_op2 = rf_rdata2;
        if (rs2 == 5'd0) begin
            w_op2 = '0;
        end else if (wb_regwrite && (wb_rd == rs2)) begin
            w_op2 = wb_data;
        end
    end

    assign w_hazard = r_ex_valid && r_ctrl.memread && (r_rd != 5'd0) &&
                      ((w_use1 && (r_rd == rs1)) || (w_use2 && (r_rd == rs2)));
    assign w_load     = !r_ex_valid || ex_ready;
    assign if_ready   = flush || (w_load && !w_hazard);
    assign w_cnt_full = (r_bubble_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_pc         <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_imm        <= '0;
            r_rd         <= '0;
            r_opcode     <= '0;
            r_funct3     <= '0;
            r_funct7     <= '0;
            r_ctrl       <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_load && w_hazard && if_valid) begin
            // One bubble is enough: the load reaches MEM next cycle and
            // downstream forwarding covers the dependent instruction.
            r_ex_valid <= 1'b0;
            if (!w_cnt_full) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (w_load && if_valid) begin
            r_ex_valid <= 1'b1;
            r_pc       <= if_pc;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_opcode   <= w_opcode;
            r_funct3   <= if_instr[14:12];
            r_funct7   <= if_instr[31:25];
            r_ctrl     <= w_ctrl;
        end else if (w_load) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_pc;
    assign ex_op1      = r_op1;
    assign ex_op2      = r_op2;
    assign ex_imm      = r_imm;
    assign ex_rd       = r_rd;
    assign ex_opcode   = r_opcode;
    assign ex_funct3   = r_funct3;
    assign ex_funct7   = r_funct7;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_alusrc   = r_ctrl.alusrc;
    assign ex_illegal  = r_ctrl.illegal;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against an instruction-level
// reference model of the ID/EX register, hazard bubbles and bypass rules.
module tb_decode_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  rf_rdata1;
    logic [XLEN-1:0]  rf_rdata2;
    logic             wb_regwrite;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_op1;
    logic [XLEN-1:0]  ex_op2;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rd;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_alusrc;
    logic             ex_illegal;
    logic [CNT_W-1:0] bubble_cnt;

    decode_stage #(
        .XLEN (XLEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .rs1        (rs1),
        .rs2        (rs2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_regwrite(wb_regwrite),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .ex_imm     (ex_imm),
        .ex_rd      (ex_rd),
        .ex_opcode  (ex_opcode),
        .ex_funct3  (ex_funct3),
        .ex_funct7  (ex_funct7),
        .ex_regwrite(ex_regwrite),
        .ex_memread (ex_memread),
        .ex_memwrite(ex_memwrite),
        .ex_alusrc  (ex_alusrc),
        .ex_illegal (ex_illegal),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] regs [32];
    logic        t_if_ready;

    // Reference model state of the ID/EX register.
    logic        m_valid;
    int          m_bub;
    logic [63:0] m_pc, m_op1, m_op2, m_imm;
    logic [4:0]  m_rd;
    logic [6:0]  m_opc, m_f7;
    logic [2:0]  m_f3;
    logic        m_rw, m_mr, m_mw, m_as, m_ill;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction class table: what each opcode does and which sources it reads.
    function automatic void m_class(input logic [6:0] opc, output logic rw, output logic mr,
                                    output logic mw, output logic as, output logic ill,
                                    output logic u1, output logic u2);
        rw = 0; mr = 0; mw = 0; as = 0; ill = 0; u1 = 1; u2 = 0;
        case (opc)
            7'b0110111, 7'b0010111: begin rw = 1; as = 1; u1 = 0; end
            7'b1101111:             begin rw = 1; u1 = 0; end
            7'b1100111:             begin rw = 1; as = 1; end
            7'b1100011:             begin u2 = 1; end
            7'b0000011:             begin rw = 1; mr = 1; as = 1; end
            7'b0100011:             begin mw = 1; as = 1; u2 = 1; end
            7'b0010011, 7'b0011011: begin rw = 1; as = 1; end
            7'b0110011, 7'b0111011: begin rw = 1; u2 = 1; end
            default:                begin ill = 1; end
        endcase
    endfunction

    // Immediate value computed arithmetically from the field weights.
    function automatic logic [63:0] calc_imm(input logic [31:0] ins);
        longint v;
        v = 0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                v = longint'(ins[30:20]);
                if (ins[31]) v -= 2048;
            end
            7'b0100011: begin
                v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 2048;
            end
            7'b1100011: begin
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
            end
            7'b0110111, 7'b0010111: begin
                v = longint'(ins[30:12]) * 4096;
                if (ins[31]) v -= 64'sd2147483648;
            end
            7'b1101111: begin
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v -= 1048576;
            end
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_bub = 0;
        m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0;
        m_opc = 0; m_f7 = 0; m_f3 = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0; m_ill = 0;
    endtask

    task automatic chk_all();
        chk("ex_valid", ex_valid, m_valid);
        chk("bubble_cnt", bubble_cnt, 64'(m_bub));
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_op1", ex_op1, m_op1);
        chk("ex_op2", ex_op2, m_op2);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_rd", ex_rd, m_rd);
        chk("ex_opcode", ex_opcode, m_opc);
        chk("ex_funct3", ex_funct3, m_f3);
        chk("ex_funct7", ex_funct7, m_f7);
        chk("ex_regwrite", ex_regwrite, m_rw);
        chk("ex_memread", ex_memread, m_mr);
        chk("ex_memwrite", ex_memwrite, m_mw);
        chk("ex_alusrc", ex_alusrc, m_as);
        chk("ex_illegal", ex_illegal, m_ill);
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        if_valid  = v;
        if_instr  = ins;
        if_pc     = pc;
        rf_rdata1 = regs[ins[19:15]];
        rf_rdata2 = regs[ins[24:20]];
    endtask

    // One clock: check combinational outputs, then advance model and DUT together.
    task automatic tick();
        logic rw, mr, mw, as, ill, u1, u2, haz, load, exp_rdy;
        logic [4:0] a1, a2;
        logic [63:0] e1, e2;
        #1;
        a1 = if_instr[19:15];
        a2 = if_instr[24:20];
        m_class(if_instr[6:0], rw, mr, mw, as, ill, u1, u2);
        haz = m_valid && m_mr && (m_rd != 0) && ((u1 && m_rd == a1) || (u2 && m_rd == a2));
        load = !m_valid || ex_ready;
        exp_rdy = flush || (load && !haz);
        e1 = (a1 == 0) ? 64'd0 : (wb_regwrite && wb_rd == a1) ? wb_data : rf_rdata1;
        e2 = (a2 == 0) ? 64'd0 : (wb_regwrite && wb_rd == a2) ? wb_data : rf_rdata2;
        chk("rs1", rs1, a1);
        chk("rs2", rs2, a2);
        chk("if_ready", if_ready, exp_rdy);
        t_if_ready = if_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 0;
        end else if (load && haz && if_valid) begin
            m_valid = 0;
            if (m_bub < CNT_MAX) m_bub++;
        end else if (load && if_valid) begin
            m_valid = 1;
            m_pc = if_pc; m_op1 = e1; m_op2 = e2; m_imm = calc_imm(if_instr);
            m_rd = rw ? if_instr[11:7] : 5'd0;
            m_opc = if_instr[6:0]; m_f3 = if_instr[14:12]; m_f7 = if_instr[31:25];
            m_rw = rw; m_mr = mr; m_mw = mw; m_as = as; m_ill = ill;
        end else if (load) begin
            m_valid = 0;
        end
        chk_all();
    endtask

    logic [6:0] opcs [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                              7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                              7'b0011011, 7'b0110011, 7'b0111011, 7'b1111111};

    initial begin
        logic [31:0] ins;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        regs[0] = 64'hDEAD_BEEF_0000_0001;
        regs[1] = 64'h10;
        regs[2] = 64'h55;
        rst_n = 1'b0; flush = 0; ex_ready = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        set_fetch(0, 32'h0, 64'h0);
        model_reset();
        #3;
        chk_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x5,x0,-1
        ex_ready = 1;
        set_fetch(1, 32'hFFF00293, 64'h1000);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", ex_rd, 5);
        chk("addi_regwrite", ex_regwrite, 1);
        chk("addi_alusrc", ex_alusrc, 1);
        chk("addi_x0_op1", ex_op1, 0);

        // add x3,x1,x2 with writeback bypass on x2, then with wb_rd=0
        set_fetch(1, 32'h002081B3, 64'h1004);
        wb_regwrite = 1; wb_rd = 2; wb_data = 64'h99;
        tick();
        chk("byp_op1", ex_op1, 64'h10);
        chk("byp_op2", ex_op2, 64'h99);
        wb_rd = 0;
        tick();
        chk("nobyp_op2", ex_op2, 64'h55);
        wb_regwrite = 0;

        // ld x7,0(x1) then add x8,x7,x7: one bubble
        set_fetch(1, 32'h0000B383, 64'h1008);
        tick();
        chk("ld_memread", ex_memread, 1);
        set_fetch(1, 32'h00738433, 64'h100C);
        tick();
        chk("lu_if_ready", t_if_ready, 0);
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        tick();
        chk("lu_if_ready_after", t_if_ready, 1);
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 8);

        // sw x2,8(x1) held under 3 cycles of backpressure
        set_fetch(1, 32'h0020A423, 64'h1010);
        tick();
        chk("sw_memwrite", ex_memwrite, 1);
        chk("sw_imm", ex_imm, 8);
        chk("sw_rd", ex_rd, 0);
        ex_ready = 0;
        set_fetch(1, 32'h00500313, 64'h1014);
        repeat (3) begin
            tick();
            chk("bp_if_ready", t_if_ready, 0);
            chk("bp_valid", ex_valid, 1);
            chk("bp_opcode", ex_opcode, 7'h23);
            chk("bp_pc", ex_pc, 64'h1010);
        end
        ex_ready = 1;
        tick();
        chk("rel_if_ready", t_if_ready, 1);
        chk("rel_rd", ex_rd, 6);
        chk("rel_imm", ex_imm, 5);

        // flush with a stalled ID/EX beat and a waiting fetch beat
        ex_ready = 0;
        flush = 1;
        set_fetch(1, 32'h002081B3, 64'h1018);
        tick();
        chk("flush_if_ready", t_if_ready, 1);
        chk("flush_valid", ex_valid, 0);
        flush = 0;
        ex_ready = 1;

        // illegal opcode
        set_fetch(1, 32'h0000037F, 64'h101C);
        tick();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_regwrite", ex_regwrite, 0);
        chk("ill_rd", ex_rd, 0);

        // ld x7,0(x7) repeatedly: a bubble every other cycle, past saturation
        set_fetch(1, 32'h0003B383, 64'h1020);
        repeat (2 * (CNT_MAX + 2)) tick();
        chk("sat_cnt", bubble_cnt, CNT_MAX);

        // asynchronous reset between clock edges
        set_fetch(1, 32'hFFF00293, 64'h1024);
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_cnt", bubble_cnt, 0);
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        if_valid = 0;
        t_if_ready = 1;
        for (int n = 0; n < 2000; n++) begin
            if (!(if_valid && !t_if_ready)) begin
                ins = $urandom;
                ins[6:0]   = opcs[$urandom_range(0, 11)];
                ins[11:7]  = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
                if_valid = ($urandom_range(0, 3) != 0);
                if_pc = {$urandom, $urandom};
            end else begin
                ins = if_instr;
            end
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = {$urandom, $urandom};
            set_fetch(if_valid, ins, if_pc);
            ex_ready    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_regwrite = $urandom_range(0, 1) == 1;
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
